rot_shift_unit: RTL and testbench

ROT_SHIFT_UNIT -- requirements
Module: rot_shift_unit

---
 rtl/rot_pkg.sv | 28 ++
 rtl/rot_shift_unit_if.sv | 25 ++
 rtl/rot_step.sv | 49 ++++
 rtl/rot_shift_unit.sv | 116 +++++++++++
 tb/tb_rot_shift_unit.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/rot_pkg.sv
// Shared types for the rotate/shift unit: op encoding, FSM states and the width log2 helper.
package rot_pkg;

    typedef enum logic [2:0] {
        OP_ROL = 3'd0,
        OP_ROR = 3'd1,
        OP_SHL = 3'd2,
        OP_SHR = 3'd3,
        OP_SRA = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Smallest r with 2^r >= w; exact log2 for the power-of-two widths used here.
    function automatic int log2w(input int w);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < w) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rot_shift_unit_if.sv
// Request/result handshake bundle for rot_shift_unit; slave is the unit, master the client.
interface rot_shift_unit_if #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] data_in;
    logic [AMT_W-1:0] amount;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             zero;

    modport slave (
        input  in_valid, op, data_in, amount, out_ready,
        output in_ready, out_valid, data_out, zero
    );

    modport master (
        output in_valid, op, data_in, amount, out_ready,
        input  in_ready, out_valid, data_out, zero
    );
endinterface

// File: rtl/rot_step.sv
// One conditional 2^k rotate/shift stage; the top iterates it over k = 0..log2(WIDTH)-1.
module rot_step
    import rot_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LOG2  = log2w(WIDTH),
    parameter int K_W   = (LOG2 > 1) ? $clog2(LOG2) : 1
) (
    input  logic [WIDTH-1:0] word,
    input  logic [2:0]       op,
    input  logic [K_W-1:0]   k,
    input  logic             en,
    input  logic             fill,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] rol_s [LOG2];
    logic [WIDTH-1:0] ror_s [LOG2];
    logic [WIDTH-1:0] shl_s [LOG2];
    logic [WIDTH-1:0] shr_s [LOG2];
    logic [WIDTH-1:0] sra_s [LOG2];

    // Every stage distance is at most WIDTH/2, so the fixed slices are always legal.
    generate
        for (genvar gi = 0; gi < LOG2; gi++) begin : g_stage
            localparam int S = 1 << gi;
            assign rol_s[gi] = {word[WIDTH-S-1:0], word[WIDTH-1:WIDTH-S]};
            assign ror_s[gi] = {word[S-1:0], word[WIDTH-1:S]};
            assign shl_s[gi] = {word[WIDTH-S-1:0], {S{1'b0}}};
            assign shr_s[gi] = {{S{1'b0}}, word[WIDTH-1:S]};
            assign sra_s[gi] = {{S{fill}}, word[WIDTH-1:S]};
        end
    endgenerate

    always_comb begin
        result = word;
        if (en) begin
            case (op)
                OP_ROL:  result = rol_s[k];
                OP_ROR:  result = ror_s[k];
                OP_SHL:  result = shl_s[k];
                OP_SHR:  result = shr_s[k];
                OP_SRA:  result = sra_s[k];
                default: result = word;
            endcase
        end
    end

endmodule

// File: rtl/rot_shift_unit.sv
// Bit-serial-by-stage rotate/shift unit: one 2^k stage per RUN cycle, IDLE/RUN/DONE handshake.
// Optional build macro ROT_EARLY_EXIT_EN finishes as soon as no higher count bits remain.
module rot_shift_unit
    import rot_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    rot_shift_unit_if.slave bus
);

    localparam int LOG2 = log2w(WIDTH);
    localparam int K_W  = (LOG2 > 1) ? $clog2(LOG2) : 1;

    state_e           state_reg, state_next;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] word_reg;
    logic [LOG2-1:0]  cnt_reg;
    logic [K_W-1:0]   k_reg;
    logic             fill_reg;

    logic [LOG2-1:0]  eff_cnt;
    logic [WIDTH-1:0] step_out;
    logic             accept;
    logic             last_step;
    logic             hi_zero;
    logic [LOG2-1:0]  cnt_rem;

    // Reduce the full amount so every bit participates; synthesises to the low LOG2 bits.
    assign eff_cnt   = LOG2'(bus.amount % AMT_W'(WIDTH));
    assign accept    = (state_reg == ST_IDLE) && bus.in_valid;
    assign last_step = (k_reg == K_W'(LOG2 - 1));
    assign cnt_rem   = cnt_reg >> k_reg;
    assign hi_zero   = ((cnt_rem >> 1) == '0);

    rot_step #(
        .WIDTH (WIDTH),
        .LOG2  (LOG2),
        .K_W   (K_W)
    ) u_step (
        .word   (word_reg),
        .op     (op_reg),
        .k      (k_reg),
        .en     (cnt_reg[k_reg]),
        .fill   (fill_reg),
        .result (step_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
`ifdef ROT_EARLY_EXIT_EN
                    state_next = (eff_cnt == '0) ? ST_DONE : ST_RUN;
`else
                    state_next = ST_RUN;
`endif
                end
            end
            ST_RUN: begin
`ifdef ROT_EARLY_EXIT_EN
                if (last_step || hi_zero) state_next = ST_DONE;
`else
                if (last_step) state_next = ST_DONE;
`endif
            end
            ST_DONE: begin
                if (bus.out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_reg == ST_IDLE);
        bus.out_valid = (state_reg == ST_DONE);
        bus.data_out  = (state_reg == ST_DONE) ? word_reg : '0;
        bus.zero      = (state_reg == ST_DONE) && (word_reg == '0);
    end

    // Datapath: capture on accept, one stage per RUN cycle, frozen in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg   <= '0;
            word_reg <= '0;
            cnt_reg  <= '0;
            k_reg    <= '0;
            fill_reg <= 1'b0;
        end else if (accept) begin
            op_reg   <= bus.op;
            word_reg <= bus.data_in;
            cnt_reg  <= eff_cnt;
            k_reg    <= '0;
            fill_reg <= bus.data_in[WIDTH-1];
        end else if (state_reg == ST_RUN) begin
            word_reg <= step_out;
            k_reg    <= k_reg + 1'b1;
        end
    end

    // hi_zero only steers the early-exit build.
    logic unused_ok;
    assign unused_ok = hi_zero;

endmodule

// File: tb/tb_rot_shift_unit.sv
// Directed-vector bench for rot_shift_unit: table of operations plus stall and mid-RUN reset sequences.
module tb_rot_shift_unit;

    localparam int WIDTH = 32;
    localparam int AMT_W = 32;

    logic clk;
    logic rst_n;

    rot_shift_unit_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

    rot_shift_unit #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] data;
        logic [31:0] amt;
        logic [31:0] expv;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    int checks;
    int errors;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    function automatic int exp_latency(input logic [31:0] amt);
        int lat;
        logic [4:0] e;
        e = amt[4:0];
`ifdef ROT_EARLY_EXIT_EN
        lat = 1;
        for (int i = 0; i < 5; i++) if (e[i]) lat = i + 1;
`else
        lat = 5;
        if (e == 5'd31) lat = 5;
`endif
        return lat;
    endfunction

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk({name, " in_ready timeout"}, 32'd0, 32'd1);
    endtask

    // Issues one request, measures latency, checks result, then completes the handshake.
    task automatic run_vec(input string name, input logic [2:0] op, input logic [31:0] data,
                           input logic [31:0] amt, input logic [31:0] expv);
        int lat;
        wait_ready(name);
        bus.op       = op;
        bus.data_in  = data;
        bus.amount   = amt;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.data_in  = 32'hDEAD_BEEF;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (bus.out_valid !== 1'b1 && lat < 20);
        chk({name, " latency"}, 32'(lat), 32'(exp_latency(amt)));
        chk({name, " data_out"}, bus.data_out, expv);
        chk({name, " zero"}, {31'd0, bus.zero}, {31'd0, (expv == 32'd0)});
        $display("op=%0d data=%h amt=%0d -> data_out=%h zero=%0b latency=%0d",
                 op, data, amt, bus.data_out, bus.zero, lat);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({name, " out_valid after take"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = 3'd0;
        bus.data_in   = '0;
        bus.amount    = '0;

        vecs[0]  = '{3'd0, 32'h8000_0001, 32'd1,  32'h0000_0003};
        vecs[1]  = '{3'd1, 32'h0000_0001, 32'd4,  32'h1000_0000};
        vecs[2]  = '{3'd4, 32'h8000_0000, 32'd4,  32'hF800_0000};
        vecs[3]  = '{3'd3, 32'h8000_0000, 32'd31, 32'h0000_0001};
        vecs[4]  = '{3'd0, 32'h0000_0001, 32'd33, 32'h0000_0002};
        vecs[5]  = '{3'd2, 32'h1234_5678, 32'd32, 32'h1234_5678};
        vecs[6]  = '{3'd2, 32'h0000_0001, 32'd31, 32'h8000_0000};
        vecs[7]  = '{3'd2, 32'h8000_0000, 32'd1,  32'h0000_0000};
        vecs[8]  = '{3'd5, 32'h0000_ABCD, 32'd7,  32'h0000_ABCD};
        vecs[9]  = '{3'd4, 32'h7000_0000, 32'd4,  32'h0700_0000};
        vecs[10] = '{3'd1, 32'h1234_5678, 32'd8,  32'h7812_3456};
        vecs[11] = '{3'd3, 32'hFFFF_FFFF, 32'd0,  32'hFFFF_FFFF};
        vecs[12] = '{3'd0, 32'h1234_5678, 32'd28, 32'h8123_4567};
        vecs[13] = '{3'd4, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF};
        vecs[14] = '{3'd2, 32'h0000_0001, 32'd3,  32'h0000_0008};
        vecs[15] = '{3'd1, 32'h0000_0001, 32'd16, 32'h0001_0000};

        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset data_out", bus.data_out, 32'd0);
        chk("reset zero", {31'd0, bus.zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset in_ready", {31'd0, bus.in_ready}, 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].amt, vecs[i].expv);
        end

        // Stall in DONE with a competing request that must be ignored.
        wait_ready("stall");
        bus.op = 3'd0; bus.data_in = 32'h8000_0001; bus.amount = 32'd1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        begin
            int n;
            n = 0;
            while (bus.out_valid !== 1'b1 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
        end
        bus.op = 3'd2; bus.data_in = 32'h0000_FFFF; bus.amount = 32'd5; bus.in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("stall%0d out_valid", c), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("stall%0d data_out", c), bus.data_out, 32'h0000_0003);
            chk($sformatf("stall%0d in_ready", c), {31'd0, bus.in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        $display("stall: held result %h for 3 cycles", bus.data_out);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("stall release out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("stall release in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("stall no capture", {31'd0, bus.in_ready}, 32'd1);

        // Reset pulse mid-RUN abandons the request.
        wait_ready("rstrun");
        bus.op = 3'd1; bus.data_in = 32'h0000_00F0; bus.amount = 32'd4; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rstrun in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rstrun out_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int c = 0; c < 8; c++) begin
                @(posedge clk); #1;
                if (bus.out_valid === 1'b1) seen = 1'b1;
            end
            chk("rstrun no result", {31'd0, seen}, 32'd0);
        end
        $display("rstrun: request abandoned by reset");
        run_vec("post_reset", 3'd0, 32'h8000_0001, 32'd1, 32'h0000_0003);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running, required finished");
        $fatal(1, "timeout");
    end

endmodule
